// File: rtl/bsg_wormhole_packet_deserializer_if.sv
// rtl/bsg_wormhole_packet_deserializer_if.sv - link-side and packet-side handshake bundle
//
// Purpose: groups the flit input stream and the assembled-packet output of the
// wormhole packet deserializer.
// Signals:
//   link_data_i        flit_width_p    incoming flit
//   link_v_i           1               flit valid
//   link_ready_and_o   1               deserializer can accept a flit
//   packet_o           packet_width_p  assembled packet {payload, len, cord}
//   packet_v_o         1               packet valid
//   packet_ready_and_i 1               consumer ready
// Modports: slave = deserializer side, master = link driver / packet consumer side.
interface bsg_wormhole_packet_deserializer_if #(
    parameter int flit_width_p   = 8,
    parameter int packet_width_p = 23
);
    logic [flit_width_p-1:0]   link_data_i;
    logic                      link_v_i;
    logic                      link_ready_and_o;
    logic [packet_width_p-1:0] packet_o;
    logic                      packet_v_o;
    logic                      packet_ready_and_i;

    modport slave (
        input  link_data_i,
        input  link_v_i,
        input  packet_ready_and_i,
        output link_ready_and_o,
        output packet_o,
        output packet_v_o
    );

    modport master (
        output link_data_i,
        output link_v_i,
        output packet_ready_and_i,
        input  link_ready_and_o,
        input  packet_o,
        input  packet_v_o
    );
endinterface

// File: rtl/bsg_wormhole_packet_deserializer.sv
// rtl/bsg_wormhole_packet_deserializer.sv - reassembles wormhole link flits into one wide packet
//
// Purpose: accepts a header flit plus len body flits and presents the packet
// {payload, len, cord} (cord at the LSBs) on a valid/ready output.
// Ports:
//   clk_i      clock
//   reset_n_i  asynchronous active-low reset
//   link_if    slave modport: link_data_i/link_v_i/link_ready_and_o in,
//              packet_o/packet_v_o/packet_ready_and_i out
module bsg_wormhole_packet_deserializer #(
    parameter int  flit_width_p        = 8,
    parameter int  max_payload_width_p = 17,
    parameter int  cord_width_p        = 4,
    parameter int  len_width_p         = 2,
    localparam int packet_width_lp     = max_payload_width_p + len_width_p + cord_width_p,
    localparam int max_num_flits_lp    = (packet_width_lp + flit_width_p - 1) / flit_width_p
) (
    input  logic clk_i,
    input  logic reset_n_i,
    bsg_wormhole_packet_deserializer_if.slave link_if
);

    localparam int idx_width_lp = len_width_p + 1;

    typedef enum logic [1:0] {
        HEADER = 2'd0,
        BODY   = 2'd1,
        OUT    = 2'd2
    } state_e;

    state_e                     state_q, state_d;
    logic [len_width_p-1:0]     cnt_q, cnt_d;
    logic [len_width_p-1:0]     len_q, len_d;
    logic [packet_width_lp-1:0] pkt_q, pkt_d;

    logic [len_width_p-1:0]     hdr_len;
    logic [idx_width_lp-1:0]    wr_idx;
    logic                       wr_en;
    logic                       ready_raw;
    logic                       packet_v;

    assign hdr_len = link_if.link_data_i[cord_width_p +: len_width_p];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        pkt_d     = pkt_q;
        wr_idx    = '0;
        wr_en     = 1'b0;
        ready_raw = 1'b0;
        packet_v  = 1'b0;

        unique case (state_q)
            HEADER: begin
                ready_raw = 1'b1;
                if (link_if.link_v_i) begin
                    // Clearing first guarantees short packets read zero above their last flit.
                    pkt_d   = '0;
                    wr_en   = 1'b1;
                    wr_idx  = '0;
                    cnt_d   = hdr_len;
                    len_d   = hdr_len;
                    state_d = (hdr_len == '0) ? OUT : BODY;
                end
            end
            BODY: begin
                ready_raw = 1'b1;
                if (link_if.link_v_i) begin
                    wr_en  = 1'b1;
                    // counter counts down from len, so this walks flit indices 1..len.
                    wr_idx = {1'b0, len_q} - {1'b0, cnt_q} + idx_width_lp'(1);
                    cnt_d  = cnt_q - len_width_p'(1);
                    if (cnt_q == len_width_p'(1)) begin
                        state_d = OUT;
                    end
                end
            end
            OUT: begin
                packet_v = 1'b1;
                if (link_if.packet_ready_and_i) begin
                    state_d = HEADER;
                end
            end
            default: begin
                state_d = HEADER;
            end
        endcase

        // Bit-wise write so flit bits past the packet width (and whole out-of-range
        // flits from an illegal len) simply fall away.
        if (wr_en) begin
            for (int k = 0; k < max_num_flits_lp; k++) begin
                if (wr_idx == idx_width_lp'(k)) begin
                    for (int b = 0; b < flit_width_p; b++) begin
                        if (k * flit_width_p + b < packet_width_lp) begin
                            pkt_d[k * flit_width_p + b] = link_if.link_data_i[b];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= HEADER;
            cnt_q   <= '0;
            len_q   <= '0;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            pkt_q   <= pkt_d;
        end
    end

    // Ready is held low while reset is asserted so no flit is taken into a flushed packet.
    assign link_if.link_ready_and_o = ready_raw & reset_n_i;
    assign link_if.packet_v_o       = packet_v;
    assign link_if.packet_o         = pkt_q;

    len_legal_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (state_q == HEADER && link_if.link_v_i) |-> (int'(hdr_len) < max_num_flits_lp));

endmodule

// File: tb/tb_bsg_wormhole_packet_deserializer.sv
// tb/tb_bsg_wormhole_packet_deserializer.sv - directed and randomized-stall bench for the packet deserializer
module tb_bsg_wormhole_packet_deserializer;

    logic clk;
    logic rst_n;
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   fail_cnt  = 0;

    bsg_wormhole_packet_deserializer_if #(.flit_width_p(8), .packet_width_p(23)) lif ();

    bsg_wormhole_packet_deserializer #(
        .flit_width_p(8),
        .max_payload_width_p(17),
        .cord_width_p(4),
        .len_width_p(2)
    ) dut (
        .clk_i(clk),
        .reset_n_i(rst_n),
        .link_if(lif.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents a flit from a negedge and returns #1 after the edge that accepted it.
    task automatic send_flit(input logic [7:0] d);
        int waitc;
        waitc = 0;
        @(negedge clk);
        lif.link_v_i    = 1'b1;
        lif.link_data_i = d;
        while (!lif.link_ready_and_o && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        if (waitc >= 200) check("send_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        lif.link_v_i = 1'b0;
    endtask

    task automatic take_packet();
        @(negedge clk);
        lif.packet_ready_and_i = 1'b1;
        @(posedge clk);
        #1;
        check("post_take_v", 32'(lif.packet_v_o), 32'd0);
        check("post_take_ready", 32'(lif.link_ready_and_o), 32'd1);
        @(negedge clk);
        lif.packet_ready_and_i = 1'b0;
    endtask

    logic [31:0] exp_q[$];

    initial begin
        rst_n                  = 1'b0;
        lif.link_v_i           = 1'b0;
        lif.link_data_i        = 8'h00;
        lif.packet_ready_and_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_v", 32'(lif.packet_v_o), 32'd0);
        check("reset_pkt", 32'(lif.packet_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_ready", 32'(lif.link_ready_and_o), 32'd1);

        // 1: single-flit packet
        send_flit(8'hC5);
        check("t1_v", 32'(lif.packet_v_o), 32'd1);
        check("t1_pkt", 32'(lif.packet_o), 32'h0000C5);
        check("t1_ready", 32'(lif.link_ready_and_o), 32'd0);
        take_packet();

        // 2: three flits back-to-back
        send_flit(8'hA7);
        check("t2_v_after1", 32'(lif.packet_v_o), 32'd0);
        send_flit(8'h3C);
        check("t2_v_after2", 32'(lif.packet_v_o), 32'd0);
        send_flit(8'h5F);
        check("t2_v", 32'(lif.packet_v_o), 32'd1);
        check("t2_pkt", 32'(lif.packet_o), 32'h5F3CA7);

        // 3: consumer stall keeps packet stable and link blocked
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_pkt_stable", 32'(lif.packet_o), 32'h5F3CA7);
            check("t3_v_held", 32'(lif.packet_v_o), 32'd1);
            check("t3_link_blocked", 32'(lif.link_ready_and_o), 32'd0);
        end
        take_packet();

        // 4: long packet then short packet, upper bits must clear
        send_flit(8'h22);
        send_flit(8'h11);
        send_flit(8'h33);
        check("t4_pkt_long", 32'(lif.packet_o), 32'h331122);
        take_packet();
        send_flit(8'h05);
        check("t4_v_short", 32'(lif.packet_v_o), 32'd1);
        check("t4_pkt_short", 32'(lif.packet_o), 32'h000005);
        take_packet();

        // 5: reset mid-packet
        send_flit(8'hA7);
        rst_n = 1'b0;
        #1;
        check("t5_v_in_reset", 32'(lif.packet_v_o), 32'd0);
        check("t5_pkt_in_reset", 32'(lif.packet_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t5_ready_after", 32'(lif.link_ready_and_o), 32'd1);
        send_flit(8'hC5);
        check("t5_v", 32'(lif.packet_v_o), 32'd1);
        check("t5_pkt", 32'(lif.packet_o), 32'h0000C5);
        take_packet();

        // 6: random bubbles and back-pressure over 200 packets
        fork
            begin
                for (int p = 0; p < 200; p++) begin
                    logic [1:0]  len;
                    logic [7:0]  flits[3];
                    logic [23:0] w;
                    len      = 2'($urandom_range(0, 2));
                    flits[0] = {2'($urandom_range(0, 3)), len, 4'($urandom_range(0, 15))};
                    flits[1] = 8'($urandom_range(0, 255));
                    flits[2] = 8'($urandom_range(0, 255));
                    w = 24'h0;
                    for (int k = 0; k <= int'(len); k++) w[k*8 +: 8] = flits[k];
                    exp_q.push_back({9'h0, w[22:0]});
                    for (int k = 0; k <= int'(len); k++) begin
                        repeat ($urandom_range(0, 2)) @(negedge clk);
                        send_flit(flits[k]);
                    end
                end
            end
            begin
                int got;
                int cyc;
                logic r;
                logic [31:0] e;
                got = 0;
                cyc = 0;
                while (got < 200 && cyc < 20000) begin
                    @(negedge clk);
                    cyc++;
                    r = 1'($urandom_range(0, 1));
                    lif.packet_ready_and_i = r;
                    if (lif.packet_v_o && r) begin
                        if (exp_q.size() == 0) begin
                            check("t6_extra_packet", 32'(lif.packet_o), 32'hFFFFFFFF);
                        end else begin
                            e = exp_q.pop_front();
                            check("t6_pkt", 32'(lif.packet_o), e);
                        end
                        got++;
                    end
                end
                if (got < 200) check("t6_timeout", 32'(got), 32'd200);
                @(negedge clk);
                lif.packet_ready_and_i = 1'b0;
            end
        join
        check("t6_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
